wb_cmd_master: RTL and testbench

- Pipelined Wishbone B4 initiator that issues one single-beat read or write per command.
- Takes commands on a valid/ready command port, drives the wb_* bus, and returns read data plus a completion status on a valid/ready response port.
- Serves as the bus-side driver for cheby-generated register maps, in firmware sequencers and in test harnesses.
- Handles stall, ack, err and rty, with a per-attempt timeout and bounded retry.

---
 rtl/wb_master_pkg.sv | 18 +
 rtl/wb_cmd_master.sv | 149 ++++++++++++++
 tb/tb_wb_cmd_master.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// Shared types for the Wishbone command master: FSM state encoding and
// the completion status codes returned on the response port.
package wb_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_WAIT    = 3'd2,
      ST_BACKOFF = 3'd3,
      ST_RESP    = 3'd4
   } wbm_state_t;

   localparam logic [1:0] WBM_OK        = 2'b00;
   localparam logic [1:0] WBM_ERR       = 2'b01;
   localparam logic [1:0] WBM_TIMEOUT   = 2'b10;
   localparam logic [1:0] WBM_RETRY_EXH = 2'b11;

endpackage

// File: rtl/wb_cmd_master.sv
// Pipelined Wishbone B4 initiator: one single-beat read or write per command,
// with stall handling, err/rty/ack termination, per-attempt timeout and bounded retry.
module wb_cmd_master
   import wb_master_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255,
   parameter int MAX_RETRY  = 3
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   // Both ports use valid/ready: a transfer happens on a rising edge where
   // valid and ready are both high; valid-side payload holds until then.
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic                    cmd_we_i,
   input  logic [ADDR_WIDTH-1:0]   cmd_adr_i,
   input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
   input  logic [DATA_WIDTH-1:0]   cmd_dat_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_dat_o,
   output logic [1:0]              rsp_status_o,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic                    wb_ack_i,
   input  logic                    wb_err_i,
   input  logic                    wb_rty_i,
   input  logic                    wb_stall_i
);

   localparam int          RW       = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   wbm_state_t              state, state_d;
   logic [15:0]             tmo_cnt, tmo_d;
   logic [RW-1:0]           retry_cnt, retry_d;
   logic                    we_d;
   logic [ADDR_WIDTH-1:0]   adr_d;
   logic [DATA_WIDTH/8-1:0] sel_d;
   logic [DATA_WIDTH-1:0]   dat_d;
   logic [DATA_WIDTH-1:0]   rsp_dat_d;
   logic [1:0]              status_d;
   logic                    term_en;

   assign cmd_ready_o = (state == ST_IDLE);

   // A termination only counts once the strobe has been taken (stall low).
   assign term_en = (state == ST_WAIT) || ((state == ST_REQ) && !wb_stall_i);

   always_comb begin
      state_d   = state;
      tmo_d     = tmo_cnt;
      retry_d   = retry_cnt;
      we_d      = wb_we_o;
      adr_d     = wb_adr_o;
      sel_d     = wb_sel_o;
      dat_d     = wb_dat_o;
      rsp_dat_d = rsp_dat_o;
      status_d  = rsp_status_o;
      case (state)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               state_d = ST_REQ;
               we_d    = cmd_we_i;
               adr_d   = cmd_adr_i;
               sel_d   = cmd_sel_i;
               dat_d   = cmd_dat_i;
               retry_d = '0;
               tmo_d   = '0;
            end
         end
         ST_REQ, ST_WAIT: begin
            if (term_en && wb_err_i) begin
               rsp_dat_d = '0;
               status_d  = WBM_ERR;
               state_d   = ST_RESP;
            end else if (term_en && wb_rty_i) begin
               if (retry_cnt < RW'(MAX_RETRY)) begin
                  retry_d = retry_cnt + 1'b1;
                  state_d = ST_BACKOFF;
               end else begin
                  rsp_dat_d = '0;
                  status_d  = WBM_RETRY_EXH;
                  state_d   = ST_RESP;
               end
            end else if (term_en && wb_ack_i) begin
               rsp_dat_d = wb_we_o ? '0 : wb_dat_i;
               status_d  = WBM_OK;
               state_d   = ST_RESP;
            end else if (tmo_cnt == TMO_LAST) begin
               // This is the TIMEOUT-th cycle with cyc high and nothing came back.
               rsp_dat_d = '0;
               status_d  = WBM_TIMEOUT;
               state_d   = ST_RESP;
            end else begin
               tmo_d = tmo_cnt + 16'd1;
               if ((state == ST_REQ) && !wb_stall_i) state_d = ST_WAIT;
            end
         end
         ST_BACKOFF: begin
            state_d = ST_REQ;
            tmo_d   = '0;
         end
         ST_RESP: begin
            if (rsp_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus and response flags are registered copies of the next-state decode.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= ST_IDLE;
         tmo_cnt      <= '0;
         retry_cnt    <= '0;
         wb_cyc_o     <= 1'b0;
         wb_stb_o     <= 1'b0;
         wb_we_o      <= 1'b0;
         wb_adr_o     <= '0;
         wb_sel_o     <= '0;
         wb_dat_o     <= '0;
         rsp_valid_o  <= 1'b0;
         rsp_dat_o    <= '0;
         rsp_status_o <= WBM_OK;
      end else begin
         state        <= state_d;
         tmo_cnt      <= tmo_d;
         retry_cnt    <= retry_d;
         wb_cyc_o     <= (state_d == ST_REQ) || (state_d == ST_WAIT);
         wb_stb_o     <= (state_d == ST_REQ);
         wb_we_o      <= we_d;
         wb_adr_o     <= adr_d;
         wb_sel_o     <= sel_d;
         wb_dat_o     <= dat_d;
         rsp_valid_o  <= (state_d == ST_RESP);
         rsp_dat_o    <= rsp_dat_d;
         rsp_status_o <= status_d;
      end
   end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: a scripted Wishbone slave plus
// hand-computed expectations for each bus scenario.
module tb_wb_cmd_master;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_we_i = 1'b0;
   logic [31:0] cmd_adr_i = '0;
   logic [3:0]  cmd_sel_i = '0;
   logic [31:0] cmd_dat_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_dat_o;
   logic [1:0]  rsp_status_o;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i = '0;
   logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0, wb_stall_i = 1'b0;

   int total = 0;
   int bad   = 0;

   // slave script: 0 ack@3, 1 stall-until-ack@3, 2 err+rty@2, 3 rty@2, 4 silent
   int          s_mode = 4;
   int          cnt = 0;
   int          stb_hi = 0, stb_rise = 0, cyc_hi = 0, cyc_rise = 0;
   logic        stb_prev = 1'b0, cyc_prev = 1'b0;
   logic [31:0] mem = '0;
   logic [31:0] got_dat;
   logic [1:0]  got_st;
   int          seen;

   wb_cmd_master #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8), .MAX_RETRY(3)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
      .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_dat_i(cmd_dat_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
      .rsp_status_o(rsp_status_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
      .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i)
   );

   always #5 clk_i = ~clk_i;

   // Slave: looks at the settled bus each negedge and drives this cycle's response.
   always @(negedge clk_i) begin
      cnt = wb_cyc_o ? cnt + 1 : 0;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_stall_i = 1'b0; wb_dat_i = '0;
      if (wb_cyc_o) begin
         cyc_hi++;
         if (!cyc_prev) cyc_rise++;
         if (wb_stb_o) stb_hi++;
         if (wb_stb_o && !stb_prev) stb_rise++;
         case (s_mode)
            0: if (cnt == 3) wb_ack_i = 1'b1;
            1: begin wb_stall_i = (cnt < 3); if (cnt == 3) wb_ack_i = 1'b1; end
            2: if (cnt == 2) begin wb_err_i = 1'b1; wb_rty_i = 1'b1; wb_dat_i = 32'hBAD0BAD0; end
            3: if (cnt == 2) wb_rty_i = 1'b1;
            default: ;
         endcase
         if (wb_ack_i) begin
            if (wb_we_o) mem = wb_dat_o;
            else wb_dat_i = mem;
         end
      end
      stb_prev = wb_stb_o;
      cyc_prev = wb_cyc_o;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic clear_mon(input int mode);
      s_mode = mode; stb_hi = 0; stb_rise = 0; cyc_hi = 0; cyc_rise = 0;
   endtask

   // Issue one command; returns at the negedge of the first stb cycle.
   task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat);
      int n;
      n = 0;
      while (!cmd_ready_o && n < 50) begin @(negedge clk_i); n++; end
      check("cmd_ready_wait", {31'b0, cmd_ready_o}, 32'd1);
      cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_sel_i = sel; cmd_dat_i = dat;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      check("stb_latency", {30'b0, wb_cyc_o, wb_stb_o}, 32'd3);
      check("wb_adr", wb_adr_o, adr);
      check("wb_sel_we", {27'b0, wb_we_o, wb_sel_o}, {27'b0, we, sel});
      check("wb_dat", wb_dat_o, dat);
   endtask

   // Wait for the response, optionally hold it off, then accept it.
   task automatic get_rsp(input int hold, output logic [31:0] dat, output logic [1:0] st);
      int n;
      n = 0;
      while (!rsp_valid_o && n < 100) begin @(negedge clk_i); n++; end
      check("rsp_arrives", {31'b0, rsp_valid_o}, 32'd1);
      dat = rsp_dat_o;
      st  = rsp_status_o;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk_i);
         check("hold_valid", {30'b0, rsp_valid_o, cmd_ready_o}, 32'd2);
         check("hold_dat", rsp_dat_o, dat);
         check("hold_status", {30'b0, rsp_status_o}, {30'b0, st});
      end
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      check("rsp_drop_ready", {30'b0, rsp_valid_o, cmd_ready_o}, 32'd1);
   endtask

   initial begin
      repeat (3) @(negedge clk_i);
      check("rst_bus", {29'b0, wb_cyc_o, wb_stb_o, rsp_valid_o}, 32'd0);
      check("rst_adr", wb_adr_o, 32'd0);
      check("rst_rsp_dat", rsp_dat_o, 32'd0);
      check("rst_ready", {31'b0, cmd_ready_o}, 32'd1);
      rst_i = 1'b0;
      @(negedge clk_i);

      // write, ack two cycles after stb
      clear_mon(0);
      send_cmd(1'b1, 32'h0, 4'hF, 32'hDEADBEEF);
      get_rsp(0, got_dat, got_st);
      check("wr_status", {30'b0, got_st}, 32'd0);
      check("wr_dat", got_dat, 32'd0);
      check("wr_stb_cycles", stb_hi, 32'd1);
      check("wr_cyc_cycles", cyc_hi, 32'd3);
      check("wr_slave_reg", mem, 32'hDEADBEEF);

      // read, slave stalls until it acks
      clear_mon(1);
      send_cmd(1'b0, 32'h0, 4'hF, 32'h0);
      get_rsp(0, got_dat, got_st);
      check("rd_status", {30'b0, got_st}, 32'd0);
      check("rd_dat", got_dat, 32'hDEADBEEF);
      check("rd_stb_cycles", stb_hi, 32'd3);
      check("rd_stb_pulses", stb_rise, 32'd1);

      // err and rty together: err wins
      clear_mon(2);
      send_cmd(1'b0, 32'h10, 4'h3, 32'h0);
      get_rsp(0, got_dat, got_st);
      check("err_status", {30'b0, got_st}, 32'd1);
      check("err_dat", got_dat, 32'd0);
      // back-to-back: the IDLE cycle after the handshake takes the next command
      clear_mon(0);
      cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 32'h4; cmd_sel_i = 4'h1; cmd_dat_i = 32'h12345678;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      check("b2b_stb", {30'b0, wb_cyc_o, wb_stb_o}, 32'd3);
      get_rsp(0, got_dat, got_st);
      check("b2b_status", {30'b0, got_st}, 32'd0);
      check("b2b_slave_reg", mem, 32'h12345678);

      // retry on every attempt: 1 + 3 re-issues
      clear_mon(3);
      send_cmd(1'b0, 32'h20, 4'hF, 32'h0);
      get_rsp(0, got_dat, got_st);
      check("rty_status", {30'b0, got_st}, 32'd3);
      check("rty_stb_pulses", stb_rise, 32'd4);
      check("rty_cyc_pulses", cyc_rise, 32'd4);
      check("rty_dat", got_dat, 32'd0);

      // silent slave: timeout after 8 cycles of cyc
      clear_mon(4);
      send_cmd(1'b1, 32'h30, 4'hF, 32'hCAFEF00D);
      get_rsp(0, got_dat, got_st);
      check("tmo_status", {30'b0, got_st}, 32'd2);
      check("tmo_cyc_cycles", cyc_hi, 32'd8);
      check("tmo_dat", got_dat, 32'd0);

      // reset while waiting on the bus
      clear_mon(4);
      send_cmd(1'b0, 32'h40, 4'hF, 32'h0);
      @(negedge clk_i);
      check("pre_rst_wait", {30'b0, wb_cyc_o, wb_stb_o}, 32'd2);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check("mid_rst_bus", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
      @(negedge clk_i);
      check("post_rst_ready", {31'b0, cmd_ready_o}, 32'd1);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_i);
         if (rsp_valid_o || wb_cyc_o) seen++;
      end
      check("post_rst_quiet", seen, 32'd0);

      // response back-pressure for 5 cycles
      clear_mon(0);
      send_cmd(1'b0, 32'h8, 4'hF, 32'h0);
      get_rsp(5, got_dat, got_st);
      check("bp_dat", got_dat, 32'h12345678);
      check("bp_status", {30'b0, got_st}, 32'd0);

      repeat (2) @(negedge clk_i);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
